slice_serial_adder: RTL
=======================

Name: slice_serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's combinational full adder.
- Adds or subtracts two WIDTH-bit operands, SLICE bits per clock, with the carry held in a flop between slices.
- Uses a start/busy/done handshake, and adds a subtract mode, carry-out and signed-overflow flags.
- Serves datapaths that trade latency for area: one SLICE-bit adder is reused WIDTH/SLICE times.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits processed per cycle. WIDTH must be an integer multiple of SLICE. SLICE=WIDTH gives a single-slice operation.
- Derived: NSL = WIDTH/SLICE, the number of slice cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is not busy.
- a  in  WIDTH  operand A; latched at the accepting edge.
- b  in  WIDTH  operand B; latched at the accepting edge.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  mode: 0 gives a+b+cin, 1 gives a-b (cin ignored).
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse when the result is updated.
- sum  out  WIDTH  result register.
- cout  out  1  final carry-out. In subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand, carry and slice-counter registers are cleared.
  - rst has priority over every other input.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge t:
  - Latch opA=a and opB = sub ? ~b : b.
  - Set carry = sub ? 1 : cin; counter k=0.
  - Go to RUN; busy=1 after edge t; done=0.
- RUN, each edge:
  - Compute the SLICE-bit sum of opA[k], opB[k] and carry.
  - Write the slice into the internal partial-result register and update carry.
  - On the last slice (k=NSL-1), also capture the carry into the MSB for ovf.
  - Increment k.
- Last RUN edge (t+NSL):
  - Copy the partial result to sum; set cout and ovf.
  - done=1, busy=0; go to DONE.
- DONE:
  - Lasts one cycle. The next edge goes to IDLE (done=0), unless start=1, which begins a new operation directly (back-to-back).
- Latency: done is high in the cycle after edge t+NSL, exactly NSL edges after the accepting edge. Throughput is one operation per NSL+1 cycles.
- Output holding: sum, cout and ovf change only on the done edge or on reset. They hold the previous result throughout RUN and IDLE.
- Input handling:
  - start during RUN is ignored. Operands are not re-latched and no error is flagged.
  - a, b, cin and sub may change freely after acceptance without affecting the result.
- Reset mid-RUN: aborts the operation. No done pulse; outputs are cleared to 0.
- Arithmetic: modulo 2^WIDTH. The carry chain across slice boundaries must equal a WIDTH-bit ripple add.
- NSL=1: one RUN edge, then DONE.

Test Plan (WIDTH=16, SLICE=4, NSL=4):
1. Hold rst=1 for 2 edges with start=1 -> busy=0, done=0, sum=0x0000, cout=0, ovf=0; start is not accepted.
2. a=0x1234, b=0x0FCD, cin=1, sub=0, start pulse -> busy high for 4 cycles; done pulses 4 edges after acceptance; sum=0x2202, cout=0, ovf=0.
3. a=0xFFFF, b=0x0001, cin=0, sub=0 (full carry ripple across all slices) -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
4. a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
5. Accept a=0x0001, b=0x0001. Assert start with a=0xAAAA during RUN, and change a/b mid-run -> sum=0x0002. Exactly one done pulse. Start held high through the DONE cycle launches the next operation with no IDLE cycle.
6. Assert rst on the 2nd RUN cycle of a=0x00FF, b=0x0001 -> the next cycle shows busy=0, sum=0; done never pulses. The following start with the same operands gives sum=0x0100 after 4 edges.

Source files
------------

// File: rtl/slice_serial_adder_if.sv
// -----------------------------------------------------------------------------
// slice_serial_adder_if
//   Request/response bundle for the slice-serial adder.
//   master (requester): drives start, a, b, cin, sub; observes busy, done,
//                       sum, cout, ovf.
//   slave  (adder)    : the reverse directions.
// -----------------------------------------------------------------------------
interface slice_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/slice_serial_adder.sv
// -----------------------------------------------------------------------------
// slice_serial_adder
//   Multi-cycle adder/subtractor: one SLICE-bit adder is reused WIDTH/SLICE
//   times, with the carry kept in a flop between slices.
//   sub=0 computes a+b+cin, sub=1 computes a-b (as a + ~b + 1, cin ignored).
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset (clears control and result state)
//   bus  : slave side of slice_serial_adder_if
//          start (in)  request, sampled only when not busy
//          a, b  (in)  operands, latched at the accepting edge
//          cin   (in)  carry-in for add mode
//          sub   (in)  0 = add, 1 = subtract
//          busy  (out) high while slices are processed
//          done  (out) one-cycle pulse when sum/cout/ovf are updated
//          sum   (out) result register
//          cout  (out) final carry-out (subtract: 1 = no borrow)
//          ovf   (out) two's-complement overflow
// -----------------------------------------------------------------------------
module slice_serial_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  slice_serial_adder_if.slave   bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_part;
  logic               r_carry;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [SLICE-1:0]   w_sa;
  logic [SLICE-1:0]   w_sb;
  logic [SLICE:0]     w_add;
  logic [SLICE-1:0]   w_res;
  logic               w_c;
  logic               w_cmsb;
  logic [WIDTH-1:0]   w_part_nxt;

  // A new request is taken in IDLE and in DONE (back-to-back), never in RUN.
  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_k == KW'(NSL - 1));

  // Operands are shifted right after every slice, so the current slice is
  // always the low SLICE bits; no variable part-select is needed.
  assign w_sa  = r_opa[SLICE-1:0];
  assign w_sb  = r_opb[SLICE-1:0];
  assign w_add = {1'b0, w_sa} + {1'b0, w_sb} + {{SLICE{1'b0}}, r_carry};
  assign w_res = w_add[SLICE-1:0];
  assign w_c   = w_add[SLICE];

  // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ c_in.
  assign w_cmsb = w_sa[SLICE-1] ^ w_sb[SLICE-1] ^ w_res[SLICE-1];

  // Partial result fills from the top; after NSL slices slice 0 sits at bit 0.
  assign w_part_nxt = (r_part >> SLICE) | (WIDTH'(w_res) << (WIDTH - SLICE));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- datapath: operand latch, slice iteration, result capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= bus.a;
      r_opb   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ? 1'b1 : bus.cin;
      r_k     <= '0;
      r_part  <= '0;
    end else if (r_state == RUN) begin
      r_opa   <= r_opa >> SLICE;
      r_opb   <= r_opb >> SLICE;
      r_part  <= w_part_nxt;
      r_carry <= w_c;
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_sum  <= w_part_nxt;
        r_cout <= w_c;
        r_ovf  <= w_cmsb ^ w_c;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
